uart_rx: RTL and testbench

- UART receiver that consumes the serial line driven by the team's uart_tx transmitter.
- Frame format is 8N1: start bit, 8 data bits LSB first, 1 stop bit.
- The block synchronises the asynchronous rx input, validates the start bit at mid-bit, and samples data at bit centres.
- Each good byte is presented as a one-cycle valid pulse; a bad stop bit raises a framing-error pulse.
- Bit timing matches uart_tx, so a tx→rx loopback works with identical parameters.

---
 rtl/uart_rx.sv | 143 ++++++++++++++
 tb/tb_uart_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit start validation,
// bit-centre data sampling, one-cycle valid / framing_err pulses.
module uart_rx #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       framing_err,
    output logic       busy,
    output logic [2:0] dbg_state_o
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t           state_q;
    logic             rx_meta_q;
    logic             rx_s_q;
    logic [CNT_W-1:0] clk_count_q;
    logic [2:0]       bit_index_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             framing_err_q;
    logic             busy_q;

    // valid is a bare one-cycle strobe: there is no ready, so a consumer
    // must capture data_out in the cycle valid is high or lose the byte.
    assign data_out    = data_q;
    assign valid       = valid_q;
    assign framing_err = framing_err_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (CLKS_PER_BIT >= 4)
                else $fatal(1, "uart_rx: CLOCK_FREQ/BAUD_RATE must be at least 4");
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            clk_count_q   <= '0;
            bit_index_q   <= '0;
            shift_q       <= '0;
            data_q        <= 8'h00;
            valid_q       <= 1'b0;
            framing_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            rx_meta_q     <= rx;
            rx_s_q        <= rx_meta_q;
            valid_q       <= 1'b0;
            framing_err_q <= 1'b0;

            // busy tracks the state being entered, so it falls with valid.
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q     <= START;
                        clk_count_q <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                START: begin
                    if (clk_count_q == HALF_LAST) begin
                        clk_count_q <= '0;
                        if (!rx_s_q) begin
                            state_q     <= DATA;
                            bit_index_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        clk_count_q <= clk_count_q + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_count_q == BIT_LAST) begin
                        clk_count_q          <= '0;
                        shift_q[bit_index_q] <= rx_s_q;
                        if (bit_index_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_index_q <= bit_index_q + 1'b1;
                        end
                    end else begin
                        clk_count_q <= clk_count_q + 1'b1;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop-bit gives half a bit of slack to the next start edge.
                    if (clk_count_q == BIT_LAST) begin
                        clk_count_q <= '0;
                        if (rx_s_q) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            framing_err_q <= 1'b1;
                            state_q       <= BREAK;
                        end
                    end else begin
                        clk_count_q <= clk_count_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomised bench for uart_rx at 16 clocks per bit; expected
// bytes and pulse cycles come from a frame-level model of the serial line.
module tb_uart_rx;

    localparam int CPB = 16;
    // From driving the start edge to seeing the pulse: 2 synchroniser cycles,
    // then the documented HALF_BIT + 9*CLKS_PER_BIT + 1.
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       framing_err;
    logic       busy;
    logic [2:0] dbg_state;

    int n_vec;
    int n_err;
    int cyc;
    logic prev_pulse;
    logic prev_busy;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         exp_vcyc_q[$];
    int         got_vcyc_q[$];
    int         exp_fcyc_q[$];
    int         got_fcyc_q[$];

    uart_rx #(
        .CLOCK_FREQ(16),
        .BAUD_RATE (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .valid      (valid),
        .framing_err(framing_err),
        .busy       (busy),
        .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (valid || framing_err) begin
            check("pulse_exclusive", {31'b0, valid & framing_err}, 32'd0);
            check("pulse_one_cycle", {31'b0, prev_pulse}, 32'd0);
        end
        if (valid) begin
            got_q.push_back(data_out);
            got_vcyc_q.push_back(cyc);
            check("busy_low_at_valid", {31'b0, busy}, 32'd0);
            check("busy_high_before_valid", {31'b0, prev_busy}, 32'd1);
        end
        if (framing_err) got_fcyc_q.push_back(cyc);
        prev_pulse = valid | framing_err;
        prev_busy  = busy;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    // Drives one 8N1 frame; rst_at >= 0 pulses reset at that clock of the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_at);
        logic [9:0] bits;
        int start;
        bits  = {stop, b, 1'b0};
        start = cyc;
        for (int i = 0; i < 10 * CPB; i++) begin
            rx = bits[i / CPB];
            if (i == rst_at) rst = 1'b1;
            tick();
            if (i == rst_at) begin
                rst = 1'b0;
                check("rst_mid_data_out", {24'b0, data_out}, 32'h00);
                check("rst_mid_valid", {31'b0, valid}, 32'd0);
                check("rst_mid_ferr", {31'b0, framing_err}, 32'd0);
                check("rst_mid_busy", {31'b0, busy}, 32'd0);
            end
        end
        if (rst_at < 0) begin
            if (stop) begin
                exp_q.push_back(b);
                exp_vcyc_q.push_back(start + LAT);
            end else begin
                exp_fcyc_q.push_back(start + LAT);
            end
        end
    endtask

    task automatic check_events(input string tag);
        check({tag, "_n_valid"}, got_q.size(), exp_q.size());
        check({tag, "_n_ferr"}, got_fcyc_q.size(), exp_fcyc_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_byte"}, {24'b0, got_q[i]}, {24'b0, exp_q[i]});
            check({tag, "_valid_cycle"}, got_vcyc_q[i], exp_vcyc_q[i]);
        end
        for (int i = 0; i < got_fcyc_q.size() && i < exp_fcyc_q.size(); i++) begin
            check({tag, "_ferr_cycle"}, got_fcyc_q[i], exp_fcyc_q[i]);
        end
        got_q.delete();
        exp_q.delete();
        got_vcyc_q.delete();
        exp_vcyc_q.delete();
        got_fcyc_q.delete();
        exp_fcyc_q.delete();
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        prev_pulse = 1'b0;
        prev_busy  = 1'b0;
        rst        = 1'b1;
        rx         = 1'b1;

        // Reset state
        repeat (3) tick();
        check("reset_data_out", {24'b0, data_out}, 32'h00);
        check("reset_valid", {31'b0, valid}, 32'd0);
        check("reset_ferr", {31'b0, framing_err}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        idle(5);

        // Single byte with latency check
        send_frame(8'hA5, 1'b1, -1);
        idle(20);
        check("a5_data_out", {24'b0, data_out}, 32'hA5);
        check_events("single_a5");

        // Back-to-back frames, as a transmitter would send them
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h5A, 1'b1, -1);
        idle(20);
        check_events("back_to_back");

        // Short glitch: false start, no pulse
        rx = 1'b0;
        repeat (3) tick();
        check("glitch_busy_high", {31'b0, busy}, 32'd1);
        idle(30);
        check("glitch_busy_low", {31'b0, busy}, 32'd0);
        check_events("glitch");

        // Bad stop bit followed by a held-low line
        send_frame(8'h3C, 1'b0, -1);
        rx = 1'b0;
        repeat (100) tick();
        check("break_busy_held", {31'b0, busy}, 32'd1);
        idle(30);
        check("break_data_kept", {24'b0, data_out}, 32'h5A);
        check("break_busy_low", {31'b0, busy}, 32'd0);
        check_events("break");
        send_frame(8'hC3, 1'b1, -1);
        idle(20);
        check_events("after_break");

        // Reset during data bit 4; the tail of the frame stays high
        send_frame(8'hF0, 1'b1, 5 * CPB + CPB / 2);
        idle(20);
        send_frame(8'h81, 1'b1, -1);
        idle(20);
        check("after_rst_data_out", {24'b0, data_out}, 32'h81);
        check_events("mid_reset");

        // Random bytes, gaps and bad stop bits
        for (int f = 0; f < 24; f++) begin
            logic [7:0] b;
            logic       stop;
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            send_frame(b, stop, -1);
            if (!stop) begin
                rx = 1'b0;
                repeat ($urandom_range(0, 30)) tick();
                idle($urandom_range(2, 10));
            end else begin
                idle($urandom_range(0, 6));
            end
        end
        idle(30);
        check_events("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
